// File: rtl/alu_acc_sequencer.sv
// Control stage in front of an external 4-bit ALU: takes one command at a time,
// keeps the accumulator and carry flag, and returns each result over a valid/ready port.
module alu_acc_sequencer #(
  parameter logic [3:0] RESET_ACC = 4'h0,
  parameter int         CNT_W     = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [3:0]       CmdOp,
  input  logic [3:0]       CmdData,
  input  logic             CmdUseCarry,
  output logic [3:0]       AluA,
  output logic [3:0]       AluB,
  output logic [2:0]       AluControl,
  output logic             AluCin,
  input  logic [3:0]       AluOut,
  input  logic             AluCout,
  output logic             ResValid,
  input  logic             ResReady,
  output logic [3:0]       ResData,
  output logic             ResCarry,
  output logic [CNT_W-1:0] OpCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_CLRC = 4'b1001;

  state_t           state_q, state_d;
  logic [3:0]       acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic             alu_cin_q, alu_cin_d;
  logic [3:0]       op_q, op_d;
  logic [3:0]       data_q, data_d;
  logic [3:0]       res_data_q, res_data_d;
  logic             res_carry_q, res_carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      acc_q       <= RESET_ACC;
      carry_q     <= 1'b0;
      alu_b_q     <= 4'h0;
      alu_ctrl_q  <= 3'd0;
      alu_cin_q   <= 1'b0;
      op_q        <= 4'h0;
      data_q      <= 4'h0;
      res_data_q  <= 4'h0;
      res_carry_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_cin_q   <= alu_cin_d;
      op_q        <= op_d;
      data_q      <= data_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_cin_d   = alu_cin_q;
    op_d        = op_q;
    data_d      = data_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (CmdValid) begin
          op_d   = CmdOp;
          data_d = CmdData;
          // Alu* only move for ALU ops so they stay stable for the external ALU otherwise.
          if (!CmdOp[3]) begin
            alu_b_d    = CmdData;
            alu_ctrl_d = CmdOp[2:0];
            alu_cin_d  = CmdUseCarry & carry_q;
          end
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!op_q[3]) begin
          acc_d   = AluOut;
          carry_d = AluCout;
        end else begin
          case (op_q)
            OP_LOAD: acc_d   = data_q;
            OP_CLRC: carry_d = 1'b0;
            default: ;
          endcase
        end
        res_data_d  = acc_d;
        res_carry_d = carry_d;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (ResReady) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign CmdReady   = (state_q == S_IDLE);
  assign ResValid   = (state_q == S_RESP);
  assign AluA       = acc_q;
  assign AluB       = alu_b_q;
  assign AluControl = alu_ctrl_q;
  assign AluCin     = alu_cin_q;
  assign ResData    = res_data_q;
  assign ResCarry   = res_carry_q;
  assign OpCount    = cnt_q;

endmodule
